// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: access-size encodings, the
// responder state machine states and a size legality helper.
package dbus_responder_pkg;

  // Access size/sign, encoded exactly as the load/store funct3 field.
  typedef enum logic [2:0] {
    SZ_B   = 3'b000,
    SZ_H   = 3'b001,
    SZ_W   = 3'b010,
    SZ_R3  = 3'b011,
    SZ_BU  = 3'b100,
    SZ_HU  = 3'b101,
    SZ_R6  = 3'b110,
    SZ_R7  = 3'b111
  } mem_size_t;

  // Responder handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  // A size code is usable when it names a real width; the unsigned
  // variants only make sense for loads.
  function automatic logic size_is_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (mem_size_t'(f3))
      SZ_B, SZ_H, SZ_W: ok = 1'b1;
      SZ_BU, SZ_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_responder_lane_align.sv
// Combinational lane aligner for the data-bus responder.
// Loads: picks the addressed byte/halfword out of a RAM word and extends it.
// Stores: replicates the store data across lanes and builds byte enables.
// Optional macro DBUS_MISALIGN_TRAP_EN: when defined, misaligned halfword and
// word accesses are flagged; otherwise the low address bits are ignored for
// those sizes so the access is naturally aligned.
module dbus_lane_align
  import dbus_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  f3_i,
  input  logic        store_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  mem_size_t   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size      = mem_size_t'(f3_i);
  assign byte_sel  = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  assign illegal_o = !size_is_legal(f3_i, store_i);

`ifdef DBUS_MISALIGN_TRAP_EN
  assign misalign_o = (((size == SZ_H) || (size == SZ_HU)) && addr_lo_i[0]) ||
                      ((size == SZ_W) && (addr_lo_i != 2'b00));
`else
  assign misalign_o = 1'b0;
`endif

  // Lane selection, extension, store replication and byte-enable generation.
  always_comb begin
    rdata_o   = '0;
    wdata_o   = '0;
    byte_en_o = '0;
    case (size)
      SZ_B, SZ_BU: begin
        rdata_o   = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
        wdata_o   = {4{wdata_i[7:0]}};
        byte_en_o = 4'b0001 << addr_lo_i;
      end
      SZ_H, SZ_HU: begin
        rdata_o   = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        wdata_o   = {2{wdata_i[15:0]}};
        byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        rdata_o   = rword_i;
        wdata_o   = wdata_i;
        byte_en_o = 4'b1111;
      end
      default: begin
        rdata_o   = '0;
        wdata_o   = '0;
        byte_en_o = '0;
      end
    endcase
    if (illegal_o) begin
      byte_en_o = '0;
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder for the multi-cycle RV32I core. Holds a word-organised
// RAM, serves byte/halfword/word loads and stores with funct3 size and sign
// rules, inserts WAIT_STATES extra stall cycles and reports access faults.
// Optional macro DBUS_MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses into faults instead of silently aligning them.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  f3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  localparam int          IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic        NO_WAIT    = (WAIT_STATES == 0);

  dbus_state_t state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]     cur_addr;
  logic [2:0]      cur_f3;
  logic            cur_we;
  logic [31:0]     cur_wdata;
  logic [IDXW-1:0] word_idx;
  logic            in_range;
  logic [31:0]     rword;
  logic            fire;
  logic            bad;
  logic [31:0]     lane_wdata;
  logic [3:0]      lane_be;
  logic [31:0]     lane_rdata;
  logic            lane_misalign;
  logic            lane_illegal;
  logic [31:0]     rdata_d;
  logic            fault_d;

  // With zero wait states the access completes on the edge leaving IDLE,
  // before the request fields are latched, so the live inputs are used there.
  assign cur_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign cur_f3    = (state_q == IDLE) ? f3_i    : f3_q;
  assign cur_we    = (state_q == IDLE) ? we_i    : we_q;
  assign cur_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

  assign in_range = ({1'b0, cur_addr} < BYTE_LIMIT);
  assign word_idx = cur_addr[IDXW+1:2];
  assign rword    = in_range ? mem[word_idx] : 32'd0;

  // The access takes effect on the edge that enters RESP; holding reset
  // low blocks it so a store caught by reset never reaches the RAM.
  assign fire = rst && (((state_q == IDLE) && req_i && NO_WAIT) ||
                        ((state_q == WAIT) && (cnt_q == 4'd0)));

  assign bad     = lane_illegal || !in_range || lane_misalign;
  assign fault_d = bad;
  assign rdata_d = (bad || cur_we) ? 32'd0 : lane_rdata;

  // Stall is raised in the same cycle a request is first seen, and drops
  // immediately while reset is held.
  assign stall_o = rst && (((state_q == IDLE) && req_i) || (state_q == WAIT));
  assign rdata_o = rdata_q;
  assign fault_o = fault_q;

  dbus_lane_align u_lane_align (
    .addr_lo_i  (cur_addr[1:0]),
    .f3_i       (cur_f3),
    .store_i    (cur_we),
    .wdata_i    (cur_wdata),
    .rword_i    (rword),
    .wdata_o    (lane_wdata),
    .byte_en_o  (lane_be),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign),
    .illegal_o  (lane_illegal)
  );

  // Request capture, wait counting, handshake sequencing and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      if (fire) begin
        rdata_q <= rdata_d;
        fault_q <= fault_d;
      end
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            f3_q    <= f3_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
            if (NO_WAIT) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= req_i ? DONE : IDLE;
        end
        DONE: begin
          if (!req_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-enabled RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (fire && cur_we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) begin
          mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder. A one-wait-state instance is
// driven through a scoreboard; a zero-wait-state instance covers the
// held-request case. Honours DBUS_MISALIGN_TRAP_EN for misaligned loads.
module tb_dbus_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk;
  logic        rst;
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;

  logic        reqZ, weZ;
  logic [2:0]  f3Z;
  logic [31:0] addrZ, wdataZ;
  logic        stallZ;
  logic [31:0] rdataZ;
  logic        faultZ;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        chkRdata;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];

  dbus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .f3_i(f3), .addr_i(addr),
    .wdata_i(wdata), .stall_o(stall), .rdata_o(rdata), .fault_o(fault)
  );

  dbus_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dutZ (
    .clk(clk), .rst(rst), .req_i(reqZ), .we_i(weZ), .f3_i(f3Z), .addr_i(addrZ),
    .wdata_i(wdataZ), .stall_o(stallZ), .rdata_o(rdataZ), .fault_o(faultZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one access on the scoreboarded instance; inputs are scrambled
  // once the request has been captured to show they are no longer used.
  task automatic applyStimulus(input string name, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic chk, input logic [31:0] expRd, input logic expFault);
    int cyc;
    exp_t e;
    e.chkRdata = chk;
    e.rdata    = expRd;
    e.fault    = expFault;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk); #1;
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    we = ~w; f3 = 3'b010; addr = ~a; wdata = ~d;
    cyc = 0;
    @(negedge clk);
    while (stall && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (stall) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: stall still 1, expected 0", name);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Monitor: a falling stall outside reset marks a response; compare it
  // against the oldest expectation together with the stall length.
  int   stallLen = 0;
  logic prevStall = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      stallLen  = 0;
      prevStall = 1'b0;
    end else begin
      if (stall) begin
        stallLen++;
      end else if (prevStall) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected response: rdata 0x%08h, expected none", rdata);
        end else begin
          exp_t  e;
          string n;
          e = expQ.pop_front();
          n = nameQ.pop_front();
          checkOutput({n, " stall length"}, 32'(stallLen), 32'(WS + 1));
          if (e.chkRdata) checkOutput({n, " rdata"}, rdata, e.rdata);
          checkOutput({n, " fault"}, {31'd0, fault}, {31'd0, e.fault});
        end
        stallLen = 0;
      end
      prevStall = stall;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'b010; addr = '0; wdata = '0;
    reqZ = 1'b0; weZ = 1'b0; f3Z = 3'b010; addrZ = '0; wdataZ = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset fault", {31'd0, fault}, 32'd0);
    checkOutput("reset stallZ", {31'd0, stallZ}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    applyStimulus("SW DEADBEEF", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus("SW clear 0x10", 1'b1, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("SB 0x13", 1'b1, 3'b000, 32'h13, 32'hFFFFFF80, 1'b0, 32'h0, 1'b0);
    applyStimulus("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80000000, 1'b0);
    applyStimulus("LB 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    applyStimulus("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0);
    applyStimulus("SW clear 0x20", 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("SH 1234", 1'b1, 3'b001, 32'h22, 32'hABCD1234, 1'b0, 32'h0, 1'b0);
    applyStimulus("LHU 0x22", 1'b0, 3'b101, 32'h22, 32'h0, 1'b1, 32'h00001234, 1'b0);
    applyStimulus("LW after SH", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h12340000, 1'b0);
    applyStimulus("SH 8001", 1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, 32'h0, 1'b0);
    applyStimulus("LH 0x22", 1'b0, 3'b001, 32'h22, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
    applyStimulus("LW out of range", 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus("f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus("store f3 100", 1'b1, 3'b100, 32'h10, 32'h000000FF, 1'b0, 32'h0, 1'b1);
    applyStimulus("LW after bad store", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80000000, 1'b0);
`ifdef DBUS_MISALIGN_TRAP_EN
    applyStimulus("LW 0x11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus("LH 0x23", 1'b0, 3'b001, 32'h23, 32'h0, 1'b1, 32'h0, 1'b1);
`else
    applyStimulus("LW 0x11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h80000000, 1'b0);
    applyStimulus("LH 0x23", 1'b0, 3'b001, 32'h23, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
`endif
    applyStimulus("SW 0x40", 1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0, 32'h0, 1'b0);

    // Reset while the store is waiting: stall drops and nothing is written.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h40; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("reset in WAIT stall", {31'd0, stall}, 32'd0);
    checkOutput("reset in WAIT rdata", rdata, 32'd0);
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus("LW 0x40 after reset", 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h11223344, 1'b0);

    // Zero wait states with the request held three cycles.
    @(posedge clk); #1;
    reqZ = 1'b1; weZ = 1'b1; f3Z = 3'b010; addrZ = 32'h8; wdataZ = 32'h55AA55AA;
    @(negedge clk);
    checkOutput("ws0 idle stall", {31'd0, stallZ}, 32'd1);
    @(posedge clk); #1;
    wdataZ = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("ws0 resp stall", {31'd0, stallZ}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ws0 done stall", {31'd0, stallZ}, 32'd0);
    @(posedge clk); #1;
    reqZ = 1'b0;
    @(posedge clk); #1;
    reqZ = 1'b1; weZ = 1'b0; addrZ = 32'h8;
    @(negedge clk);
    checkOutput("ws0 load stall", {31'd0, stallZ}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ws0 load resp stall", {31'd0, stallZ}, 32'd0);
    checkOutput("ws0 single write rdata", rdataZ, 32'h55AA55AA);
    checkOutput("ws0 fault", {31'd0, faultZ}, 32'd0);
    @(posedge clk); #1;
    reqZ = 1'b0;

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
